bbox_scanner: RTL
=================

BBOX_SCANNER -- requirements
Module: bbox_scanner

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, horizontal screen size in pixels (clip bound).
REQ-002 SHALL have parameter SCREEN_H, default 480, vertical screen size in pixels (clip bound).
REQ-003 SHALL have port clk  in  1  sole clock, all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports tri_valid in 1 / tri_ready out 1: triangle command handshake.
REQ-006 SHALL have ports V0_x, V0_y, V1_x, V1_y, V2_x, V2_y  in  11 each, signed vertex coordinates.
REQ-007 SHALL have ports pix_valid out 1 / pix_ready in 1: pixel stream handshake.
REQ-008 SHALL have ports pixel_x, pixel_y  out  11 each, unsigned pixel coordinate of the current beat.
REQ-009 SHALL have port pix_last  out  1, marks the final pixel of a triangle.
REQ-010 SHALL have port vtx_out  out  66, latched {V0_x,V0_y,V1_x,V1_y,V2_x,V2_y} (MSB first), stable while busy.
REQ-011 SHALL have ports busy out 1 (state not IDLE) and tri_empty out 1 (one-cycle pulse, no pixels emitted).

Function
REQ-012 SHALL implement FSM IDLE -> BBOX -> SCAN -> IDLE; tri_ready = 1 only in IDLE.
REQ-013 Command transfer on tri_valid && tri_ready SHALL latch all vertices into vtx_out and enter BBOX.
REQ-014 BBOX (one cycle) SHALL compute xmin/xmax/ymin/ymax as signed 11-bit min/max of the three vertices.
REQ-015 BBOX SHALL go to IDLE with a tri_empty pulse if xmin > xmax or ymin > ymax after clipping, else to SCAN with x=xmin, y=ymin.
REQ-016 SCAN SHALL assert pix_valid continuously and emit raster order: x inner xmin..xmax, y outer ymin..ymax.
REQ-017 pixel_x, pixel_y, pix_last SHALL be registered and held stable while pix_valid && !pix_ready.
REQ-018 A beat SHALL advance only on pix_valid && pix_ready; throughput one pixel per cycle at pix_ready=1.
REQ-019 pix_last SHALL be 1 exactly on beat (xmax,ymax); its transfer SHALL return FSM to IDLE next cycle, pix_valid=0.
REQ-020 First pix_valid SHALL occur 2 cycles after command transfer; a new command is accepted no earlier than the cycle after the last beat.
REQ-021 Degenerate bbox (xmin==xmax, ymin==ymax) SHALL emit exactly one beat with pix_last=1.
REQ-022 tri_valid while busy SHALL be ignored (not latched) until IDLE.

Reset
REQ-023 rst_n low at a clk edge SHALL force IDLE, pix_valid=0, pix_last=0, pixel_x=pixel_y=0, vtx_out=0, busy=0, tri_empty=0, tri_ready=1 next cycle.
REQ-024 Reset mid-SCAN SHALL drop the in-flight triangle with no further beats.

Configuration
REQ-025 Macro BBOX_SCANNER_CLIP_EN defined: bbox SHALL be clamped to [0,SCREEN_W-1] x [0,SCREEN_H-1] in BBOX; fully off-screen triangles produce tri_empty.
REQ-026 Macro undefined: no clamping; bbox bits SHALL be used as unsigned; upstream guarantees 0..1023 coordinates; tri_empty never asserts for well-formed input.

Structure
REQ-027 Shared package raster_pkg SHALL hold COORD_W=11, default SCREEN_W/SCREEN_H, vertex struct typedef, FSM state enum.
REQ-028 One sub-module bbox_calc (combinational min/max/clamp of three vertices) SHALL be instantiated; all state stays in bbox_scanner.

Verification
REQ-029 Triangle (2,3),(4,3),(2,5), pix_ready=1 -> 9 beats (2,3)..(4,5) raster order, pix_last on (4,5), first pix_valid 2 cycles after transfer.
REQ-030 Same triangle, pix_ready toggling 1,0,1,0... -> identical 9-beat sequence, outputs stable during every stall.
REQ-031 Vertices all (7,7) -> exactly one beat (7,7) with pix_last=1, IDLE next cycle.
REQ-032 CLIP_EN, 640x480: (-5,-5),(3,-5),(-5,2) -> 12 beats x0..3, y0..2; (700,10),(710,10),(700,20) -> zero beats, one tri_empty pulse.
REQ-033 rst_n low one cycle after 4th beat of REQ-029 stimulus -> next cycle pix_valid=0, busy=0, tri_ready=1; subsequent command scans from its own ymin/xmin.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster types: coordinate width, default screen size,
// vertex struct, scanner FSM states and min/max helpers.
package raster_pkg;
  localparam int COORD_W      = 11;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } vertex_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BBOX,
    ST_SCAN
  } state_t;

  function automatic coord_t min3(
    input coord_t a,
    input coord_t b,
    input coord_t c
  );
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(
    input coord_t a,
    input coord_t b,
    input coord_t c
  );
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction
endpackage

// File: rtl/bbox_calc.sv
// Combinational bbox of three vertices: signed min/max, optional screen
// clamp (macro BBOX_SCANNER_CLIP_EN). Ports: v0..v2 in; bbox + empty out.
module bbox_calc
  import raster_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  vertex_t v0,
  input  vertex_t v1,
  input  vertex_t v2,
  output coord_t  xmin,
  output coord_t  xmax,
  output coord_t  ymin,
  output coord_t  ymax,
  output logic    empty
);
`ifdef BBOX_SCANNER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  localparam coord_t XLIM = coord_t'(SCREEN_W - 1);
  localparam coord_t YLIM = coord_t'(SCREEN_H - 1);

  coord_t xlo, xhi, ylo, yhi;

  always_comb begin
    xlo = min3(v0.x, v1.x, v2.x);
    xhi = max3(v0.x, v1.x, v2.x);
    ylo = min3(v0.y, v1.y, v2.y);
    yhi = max3(v0.y, v1.y, v2.y);
    xmin = xlo;
    xmax = xhi;
    ymin = ylo;
    ymax = yhi;
    empty = 1'b0;
    if (CLIP) begin
      // Clamp only the near side of each edge so that a box lying
      // wholly off-screen ends up inverted and reads as empty.
      if (xlo < 0)    xmin = '0;
      if (xhi > XLIM) xmax = XLIM;
      if (ylo < 0)    ymin = '0;
      if (yhi > YLIM) ymax = YLIM;
      empty = (xmin > xmax) || (ymin > ymax);
    end
  end
endmodule

// File: rtl/bbox_scanner.sv
// Triangle bbox raster scanner: latches a triangle, emits every pixel of
// its bbox in raster order on a valid/ready stream. Clamp: BBOX_SCANNER_CLIP_EN.
module bbox_scanner
  import raster_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tri_valid,
  output logic                tri_ready,
  input  logic [COORD_W-1:0]  V0_x,
  input  logic [COORD_W-1:0]  V0_y,
  input  logic [COORD_W-1:0]  V1_x,
  input  logic [COORD_W-1:0]  V1_y,
  input  logic [COORD_W-1:0]  V2_x,
  input  logic [COORD_W-1:0]  V2_y,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [COORD_W-1:0]  pixel_x,
  output logic [COORD_W-1:0]  pixel_y,
  output logic                pix_last,
  output logic [6*COORD_W-1:0] vtx_out,
  output logic                busy,
  output logic                tri_empty
);
  state_t state_q, state_d;
  logic [6*COORD_W-1:0] vtx_q, vtx_d;
  coord_t xmin_q, xmin_d;
  coord_t xmax_q, xmax_d;
  coord_t ymax_q, ymax_d;
  logic [COORD_W-1:0] px_q, px_d;
  logic [COORD_W-1:0] py_q, py_d;
  logic [COORD_W-1:0] px_inc, py_inc;
  logic last_q, last_d;
  logic empty_q, empty_d;

  vertex_t v0, v1, v2;
  coord_t bx_min, bx_max, by_min, by_max;
  logic b_empty;

  assign v0 = vertex_t'(vtx_q[65:44]);
  assign v1 = vertex_t'(vtx_q[43:22]);
  assign v2 = vertex_t'(vtx_q[21:0]);

  bbox_calc #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_bbox (
    .v0   (v0),
    .v1   (v1),
    .v2   (v2),
    .xmin (bx_min),
    .xmax (bx_max),
    .ymin (by_min),
    .ymax (by_max),
    .empty(b_empty)
  );

  assign px_inc = px_q + 11'd1;
  assign py_inc = py_q + 11'd1;

  always_comb begin
    state_d = state_q;
    vtx_d   = vtx_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    px_d    = px_q;
    py_d    = py_q;
    last_d  = last_q;
    empty_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tri_valid) begin
          vtx_d   = {V0_x, V0_y, V1_x, V1_y, V2_x, V2_y};
          state_d = ST_BBOX;
        end
      end
      ST_BBOX: begin
        if (b_empty) begin
          empty_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SCAN;
          xmin_d  = bx_min;
          xmax_d  = bx_max;
          ymax_d  = by_max;
          px_d    = bx_min;
          py_d    = by_min;
          last_d  = (bx_min == bx_max) && (by_min == by_max);
        end
      end
      ST_SCAN: begin
        if (pix_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            last_d  = 1'b0;
          end else if (px_q == xmax_q) begin
            px_d   = xmin_q;
            py_d   = py_inc;
            last_d = (py_inc == ymax_q) && (xmin_q == xmax_q);
          end else begin
            px_d   = px_inc;
            last_d = (px_inc == xmax_q) && (py_q == ymax_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vtx_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      last_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vtx_q   <= vtx_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymax_q  <= ymax_d;
      px_q    <= px_d;
      py_q    <= py_d;
      last_q  <= last_d;
      empty_q <= empty_d;
    end
  end

  assign tri_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign pix_valid = (state_q == ST_SCAN);
  assign pixel_x   = px_q;
  assign pixel_y   = py_q;
  assign pix_last  = last_q;
  assign vtx_out   = vtx_q;
  assign tri_empty = empty_q;
endmodule
